// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: borrows the register_file RS/RT read ports through a
// req/gnt handshake, captures two registers per grant and streams them out
// on a valid/ready port tagged with the register index.
module regfile_dump_unit #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int SKIP_R0  = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic              RfReq,
    input  logic              RfGnt,
    output logic [ADDR_W-1:0] RS,
    output logic [ADDR_W-1:0] RT,
    input  logic [DATA_W-1:0] dataRS,
    input  logic [DATA_W-1:0] dataRT,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] OutIdx,
    output logic              OutLast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SEND_A,
        S_SEND_B,
        S_DONE
    } state_t;

    // The pointer carries one extra bit so ptr+2 never wraps at NUM_REGS=32.
    localparam logic [ADDR_W:0]   LP_NUM      = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   LP_FIRST    = (ADDR_W+1)'(SKIP_R0);
    localparam logic [ADDR_W:0]   LP_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LP_TWO      = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_ptr;
    logic [DATA_W-1:0] r_buf_a;
    logic [DATA_W-1:0] r_buf_b;

    logic [ADDR_W:0]   w_ptr_p1;
    logic [ADDR_W:0]   w_ptr_p2;
    logic              w_load_ptr;
    logic              w_capture;
    logic              w_adv_ptr;

    assign w_ptr_p1 = r_ptr + LP_ONE;
    assign w_ptr_p2 = r_ptr + LP_TWO;

    // Next-state and output decode; Abort overrides every transition and side effect.
    always_comb begin
        w_state_nxt = r_state;
        w_load_ptr  = 1'b0;
        w_capture   = 1'b0;
        w_adv_ptr   = 1'b0;
        Busy        = 1'b1;
        Done        = 1'b0;
        RfReq       = 1'b0;
        RS          = '0;
        RT          = '0;
        OutValid    = 1'b0;
        OutData     = '0;
        OutIdx      = '0;

        unique case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    w_load_ptr  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                RfReq = 1'b1;
                RS    = r_ptr[ADDR_W-1:0];
                // A trailing single register reads the same address on both ports.
                RT    = (w_ptr_p1 == LP_NUM) ? r_ptr[ADDR_W-1:0] : w_ptr_p1[ADDR_W-1:0];
                if (RfGnt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND_A;
                end
            end
            S_SEND_A: begin
                OutValid = 1'b1;
                OutData  = r_buf_a;
                OutIdx   = r_ptr[ADDR_W-1:0];
                if (OutReady) begin
                    w_state_nxt = (w_ptr_p1 < LP_NUM) ? S_SEND_B : S_DONE;
                end
            end
            S_SEND_B: begin
                OutValid = 1'b1;
                OutData  = r_buf_b;
                OutIdx   = w_ptr_p1[ADDR_W-1:0];
                if (OutReady) begin
                    w_adv_ptr   = 1'b1;
                    w_state_nxt = (w_ptr_p2 >= LP_NUM) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                Done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (Abort) begin
            w_state_nxt = S_IDLE;
            w_load_ptr  = 1'b0;
            w_capture   = 1'b0;
            w_adv_ptr   = 1'b0;
        end
    end

    assign OutLast = OutValid && (OutIdx == LP_LAST_IDX);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Walk pointer and the pair of words captured during the granted cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr   <= '0;
            r_buf_a <= '0;
            r_buf_b <= '0;
        end else begin
            if (w_load_ptr) begin
                r_ptr <= LP_FIRST;
            end else if (w_adv_ptr) begin
                r_ptr <= w_ptr_p2;
            end
            if (w_capture) begin
                r_buf_a <= dataRS;
                r_buf_b <= dataRT;
            end
        end
    end

endmodule
